duck_sprite_fetch: RTL and testbench
====================================

Name: duck_sprite_fetch

Overview:
- Pixel-stage block directly upstream of the duck palette lookup.
- Per VGA pixel: decides whether the pixel lies inside the duck sprite and addresses the sprite index ROM.
- Returns a 4-bit palette index plus valid flag, pipelined to match ROM latency.
- Also owns the duck animation frame counter and per-frame latching of sprite position.

Parameters:
- SPR_W, 32, sprite width in pixels (power of two).
- SPR_H, 32, sprite height in pixels.
- FRAMES, 4, animation frames stored consecutively in ROM.
- ANIM_DIV, 8, video frames per animation step (1..255).
- TRANSPARENT_IDX, 0, palette index treated as see-through.
- ADDR_W, $clog2(FRAMES*SPR_W*SPR_H), ROM address width (derived; default 12).

Ports:
- Clk  in  1  pixel clock.
- Reset_n  in  1  asynchronous active-low reset.
- frame_start  in  1  one-cycle pulse at start of vertical blank.
- duck_x  in  10  sprite left edge; sampled only on frame_start.
- duck_y  in  10  sprite top edge; sampled only on frame_start.
- DrawX  in  10  current pixel column.
- DrawY  in  10  current pixel row.
- blank  in  1  1 = active video.
- rom_addr  out  ADDR_W  registered address to sprite index ROM.
- rom_data  in  4  ROM output; valid exactly 1 cycle after rom_addr.
- index  out  4  palette index to palette lookup.
- pixel_valid  out  1  1 = sprite pixel, opaque, in active video.
- anim_frame  out  $clog2(FRAMES)  current animation frame.

Behaviour:
- Reset (Reset_n=0, async):
  - rom_addr, index, pixel_valid, anim_frame, latched x/y, divide counter all 0.
  - Pipeline valid bits cleared.
  - Takes effect immediately mid-line; first valid output no earlier than 3 clocks after release.
- Position latch:
  - On frame_start, x_l<=duck_x, y_l<=duck_y.
  - Mid-frame changes to duck_x/duck_y are ignored (no tearing).
- Animation:
  - div_cnt increments on each frame_start.
  - When div_cnt==ANIM_DIV-1 on a frame_start: div_cnt<=0 and anim_frame<=(anim_frame==FRAMES-1)?0:anim_frame+1.
  - Wraps FRAMES-1 -> 0.
  - anim_frame changes on the same edge as the position latch.
- Hit test (stage 0, combinational, registered into stage 1):
  - hit = blank & DrawX>=x_l & DrawX<x_l+SPR_W & DrawY>=y_l & DrawY<y_l+SPR_H.
  - Sums computed at 11 bits so a sprite near the right/bottom edge (x_l>1023-SPR_W) does not wrap.
  - Offsets dx=DrawX-x_l, dy=DrawY-y_l.
- Stage 1 (cycle N+1): rom_addr <= anim_frame*SPR_W*SPR_H + dy*SPR_W + dx (truncated to ADDR_W); hit1<=hit.
  - When hit=0, rom_addr holds its previous value.
- Stage 2 (cycle N+2): rom_data valid; hit2<=hit1.
- Stage 3 (cycle N+3):
  - index <= hit2 ? rom_data : TRANSPARENT_IDX.
  - pixel_valid <= hit2 & (rom_data != TRANSPARENT_IDX).
- Latency: fixed 3 clocks from DrawX/DrawY/blank to index/pixel_valid, regardless of hit. Downstream delays DrawX/DrawY by 3 when compositing.
- Throughput: one pixel per clock; no stalls.
- Simultaneous frame_start and hit: the hit test uses pre-update x_l/y_l/anim_frame (registered values); new values apply from the next cycle.
- blank=0: pixel_valid is 0 three cycles later, regardless of position.

Optional Feature:
- Macro DUCK_SPRITE_FLIP_EN.
- When defined:
  - Extra input flip_h (1 bit), latched with position on frame_start.
  - When latched flip=1, the dx used for addressing is SPR_W-1-dx (horizontal mirror).
  - Hit test, latency and transparency are unchanged.
- When undefined: no flip_h port; dx is used directly.

Test Plan:
- Reset release, frame_start with duck_x=100, duck_y=50; scan DrawX=100, DrawY=50, blank=1, ROM returns 4'h3 -> rom_addr=0 one cycle later; index=3, pixel_valid=1 exactly 3 cycles after the pixel.
- Pixel DrawX=131, DrawY=81 (last sprite pixel) -> rom_addr=1023. DrawX=132 -> pixel_valid=0, index=0.
- ROM returns 0 at an in-sprite pixel -> index=0, pixel_valid=0. ROM returns 4'hB -> pixel_valid=1.
- 8 frame_start pulses -> anim_frame 0->1; pixel (100,50) then gives rom_addr=1024. 32 pulses -> anim_frame wraps 3->0.
- Change duck_x to 200 mid-frame -> hits still at 100..131 until next frame_start, then 200..231. duck_x=1000: DrawX=1023 hits, DrawX=5 does not.
- Assert Reset_n=0 mid-sprite -> pixel_valid/index/rom_addr/anim_frame go 0 immediately without a clock edge; after release no pixel_valid until 3 clocks and a new hit. (FLIP_EN build: flip_h=1, pixel (100,50) -> rom_addr=31.)

Source files
------------

// File: rtl/duck_sprite_fetch.sv
// Duck sprite pixel fetch: hit test, sprite ROM addressing and a 3-clock pipeline to the palette index.
// Optional macro DUCK_SPRITE_FLIP_EN adds a flip_h input for horizontal mirroring.
module duck_sprite_fetch #(
    parameter int          SPR_W           = 32,
    parameter int          SPR_H           = 32,
    parameter int          FRAMES          = 4,
    parameter int          ANIM_DIV        = 8,
    parameter logic [3:0]  TRANSPARENT_IDX = 4'd0,
    parameter int          ADDR_W          = $clog2(FRAMES * SPR_W * SPR_H),
    parameter int          ANIM_W          = $clog2(FRAMES)
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              frame_start,
    input  logic [9:0]        duck_x,
    input  logic [9:0]        duck_y,
`ifdef DUCK_SPRITE_FLIP_EN
    input  logic              flip_h,
`endif
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              blank,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [3:0]        rom_data,
    output logic [3:0]        index,
    output logic              pixel_valid,
    output logic [ANIM_W-1:0] anim_frame
);

    logic [9:0]        x_l_q, x_l_d;
    logic [9:0]        y_l_q, y_l_d;
    logic              flip_q, flip_d;
    logic [7:0]        div_cnt_q, div_cnt_d;
    logic [ANIM_W-1:0] anim_frame_q, anim_frame_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic              hit1_q, hit1_d;
    logic              hit2_q, hit2_d;
    logic [3:0]        index_q, index_d;
    logic              pixel_valid_q, pixel_valid_d;

    logic              hit;
    logic [10:0]       x_end, y_end;
    logic [9:0]        dx, dy, dx_eff;

    // Position, flip and animation state only move on frame_start, so a frame never tears.
    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        x_l_d        = x_l_q;
        y_l_d        = y_l_q;
        flip_d       = flip_q;
        div_cnt_d    = div_cnt_q;
        anim_frame_d = anim_frame_q;
        if (frame_start) begin
            x_l_d = duck_x;
            y_l_d = duck_y;
`ifdef DUCK_SPRITE_FLIP_EN
            flip_d = flip_h;
`endif
            if (div_cnt_q == 8'(ANIM_DIV - 1)) begin
                div_cnt_d    = '0;
                anim_frame_d = (anim_frame_q == ANIM_W'(FRAMES - 1)) ? '0 : anim_frame_q + 1'b1;
            end else begin
                div_cnt_d = div_cnt_q + 8'd1;
            end
        end
    end

    // Right/bottom bounds carried at 11 bits so a sprite hugging the screen edge does not wrap.
    always_comb begin
        x_end  = {1'b0, x_l_q} + 11'(SPR_W);
        y_end  = {1'b0, y_l_q} + 11'(SPR_H);
        hit    = blank
               & (DrawX >= x_l_q) & ({1'b0, DrawX} < x_end)
               & (DrawY >= y_l_q) & ({1'b0, DrawY} < y_end);
        dx     = DrawX - x_l_q;
        dy     = DrawY - y_l_q;
        dx_eff = flip_q ? (10'(SPR_W - 1) - dx) : dx;
    end

    // Address only advances on a hit; misses keep the ROM parked on its last address.
    always_comb begin
        rom_addr_d = rom_addr_q;
        if (hit) begin
            rom_addr_d = ADDR_W'(anim_frame_q) * ADDR_W'(SPR_W * SPR_H)
                       + ADDR_W'(dy) * ADDR_W'(SPR_W)
                       + ADDR_W'(dx_eff);
        end
        hit1_d        = hit;
        hit2_d        = hit1_q;
        index_d       = hit2_q ? rom_data : TRANSPARENT_IDX;
        pixel_valid_d = hit2_q & (rom_data != TRANSPARENT_IDX);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            x_l_q         <= '0;
            y_l_q         <= '0;
            flip_q        <= 1'b0;
            div_cnt_q     <= '0;
            anim_frame_q  <= '0;
            rom_addr_q    <= '0;
            hit1_q        <= 1'b0;
            hit2_q        <= 1'b0;
            index_q       <= '0;
            pixel_valid_q <= 1'b0;
        end else begin
            x_l_q         <= x_l_d;
            y_l_q         <= y_l_d;
            flip_q        <= flip_d;
            div_cnt_q     <= div_cnt_d;
            anim_frame_q  <= anim_frame_d;
            rom_addr_q    <= rom_addr_d;
            hit1_q        <= hit1_d;
            hit2_q        <= hit2_d;
            index_q       <= index_d;
            pixel_valid_q <= pixel_valid_d;
        end
    end

    assign rom_addr    = rom_addr_q;
    assign index       = index_q;
    assign pixel_valid = pixel_valid_q;
    assign anim_frame  = anim_frame_q;

endmodule

// File: tb/tb_duck_sprite_fetch.sv
// Directed bench for duck_sprite_fetch with a registered 1-cycle sprite ROM model.
module tb_duck_sprite_fetch;

    localparam int ADDR_W = 12;

    logic              Clk = 1'b0;
    logic              Reset_n = 1'b0;
    logic              frame_start = 1'b0;
    logic [9:0]        duck_x = '0;
    logic [9:0]        duck_y = '0;
    logic [9:0]        DrawX = '0;
    logic [9:0]        DrawY = '0;
    logic              blank = 1'b0;
    logic [ADDR_W-1:0] rom_addr;
    logic [3:0]        rom_data = '0;
    logic [3:0]        index;
    logic              pixel_valid;
    logic [1:0]        anim_frame;
`ifdef DUCK_SPRITE_FLIP_EN
    logic              flip_h = 1'b0;
`endif

    int total = 0;
    int bad   = 0;

    logic [3:0] rom_mem [0:4095];

    duck_sprite_fetch dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .frame_start (frame_start),
        .duck_x      (duck_x),
        .duck_y      (duck_y),
`ifdef DUCK_SPRITE_FLIP_EN
        .flip_h      (flip_h),
`endif
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .blank       (blank),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .index       (index),
        .pixel_valid (pixel_valid),
        .anim_frame  (anim_frame)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) rom_data <= rom_mem[rom_addr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic fs(input logic [9:0] x, input logic [9:0] y);
        @(negedge Clk);
        duck_x = x; duck_y = y; frame_start = 1'b1; blank = 1'b0;
        @(negedge Clk);
        frame_start = 1'b0;
    endtask

    task automatic fs_n(input int n);
        for (int i = 0; i < n; i++) fs(10'd100, 10'd50);
    endtask

    // One isolated pixel, followed by blanked pixels; checks address, exact 3-clock latency and output.
    task automatic probe(input string tag, input logic [9:0] x, input logic [9:0] y, input logic b,
                         input logic [ADDR_W-1:0] exp_addr, input logic [3:0] exp_idx,
                         input logic exp_pv);
        @(negedge Clk);
        DrawX = x; DrawY = y; blank = b;
        @(posedge Clk); #1;
        check({tag, ".addr"}, 32'(rom_addr), 32'(exp_addr));
        blank = 1'b0;
        @(posedge Clk); #1;
        check({tag, ".early"}, 32'(pixel_valid), 32'd0);
        @(posedge Clk); #1;
        check({tag, ".idx"}, 32'(index), 32'(exp_idx));
        check({tag, ".pv"}, 32'(pixel_valid), 32'(exp_pv));
    endtask

    initial begin
        for (int a = 0; a < 4096; a++) rom_mem[a] = 4'((a % 15) + 1);
        rom_mem[0]    = 4'h3;
        rom_mem[5]    = 4'h0;
        rom_mem[6]    = 4'hB;
        rom_mem[1023] = 4'h7;

        #1;
        check("rst.addr", 32'(rom_addr), 32'd0);
        check("rst.idx",  32'(index), 32'd0);
        check("rst.pv",   32'(pixel_valid), 32'd0);
        check("rst.anim", 32'(anim_frame), 32'd0);
        @(negedge Clk);
        Reset_n = 1'b1;

        fs(10'd100, 10'd50);
        probe("first",    10'd100, 10'd50, 1'b1, 12'd0,    4'h3, 1'b1);
        probe("last",     10'd131, 10'd81, 1'b1, 12'd1023, 4'h7, 1'b1);
        probe("right_out",10'd132, 10'd81, 1'b1, 12'd1023, 4'h0, 1'b0);
        probe("transp",   10'd105, 10'd50, 1'b1, 12'd5,    4'h0, 1'b0);
        probe("opaque_b", 10'd106, 10'd50, 1'b1, 12'd6,    4'hB, 1'b1);
        probe("left_out", 10'd99,  10'd50, 1'b1, 12'd6,    4'h0, 1'b0);
        probe("top_out",  10'd100, 10'd49, 1'b1, 12'd6,    4'h0, 1'b0);
        probe("blanked",  10'd100, 10'd50, 1'b0, 12'd6,    4'h0, 1'b0);

        fs_n(6);
        check("anim7", 32'(anim_frame), 32'd0);
        fs_n(1);
        check("anim8", 32'(anim_frame), 32'd1);
        probe("anim1_px", 10'd100, 10'd50, 1'b1, 12'd1024, 4'h5, 1'b1);
        fs_n(16);
        check("anim24", 32'(anim_frame), 32'd3);
        fs_n(8);
        check("anim32", 32'(anim_frame), 32'd0);

        @(negedge Clk);
        duck_x = 10'd200;
        probe("mid_old",  10'd100, 10'd50, 1'b1, 12'd0, 4'h3, 1'b1);
        probe("mid_new",  10'd200, 10'd50, 1'b1, 12'd0, 4'h0, 1'b0);
        fs(10'd200, 10'd50);
        probe("moved_in", 10'd200, 10'd50, 1'b1, 12'd0, 4'h3, 1'b1);
        probe("moved_out",10'd100, 10'd50, 1'b1, 12'd0, 4'h0, 1'b0);

        fs(10'd1000, 10'd50);
        probe("edge_in",  10'd1023, 10'd50, 1'b1, 12'd23, 4'h9, 1'b1);
        probe("edge_wrap",10'd5,    10'd50, 1'b1, 12'd23, 4'h0, 1'b0);

        // frame_start coinciding with a hit: old position must address the ROM
        @(negedge Clk);
        duck_x = 10'd300; frame_start = 1'b1; DrawX = 10'd1010; DrawY = 10'd50; blank = 1'b1;
        @(posedge Clk); #1;
        check("simul.addr", 32'(rom_addr), 32'd10);
        frame_start = 1'b0; blank = 1'b0;

        fs(10'd100, 10'd50);
        fs_n(4);
        check("anim_pre_rst", 32'(anim_frame), 32'd1);
        @(negedge Clk);
        DrawX = 10'd100; DrawY = 10'd50; blank = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        check("stream.pv",   32'(pixel_valid), 32'd1);
        check("stream.idx",  32'(index), 32'h5);
        check("stream.addr", 32'(rom_addr), 32'd1024);
        #2;
        Reset_n = 1'b0;
        #1;
        check("arst.pv",   32'(pixel_valid), 32'd0);
        check("arst.idx",  32'(index), 32'd0);
        check("arst.addr", 32'(rom_addr), 32'd0);
        check("arst.anim", 32'(anim_frame), 32'd0);
        @(negedge Clk);
        Reset_n = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        check("post_rst.pv", 32'(pixel_valid), 32'd0);
        blank = 1'b0;
        fs(10'd100, 10'd50);
        probe("post_rst_hit", 10'd100, 10'd50, 1'b1, 12'd0, 4'h3, 1'b1);

`ifdef DUCK_SPRITE_FLIP_EN
        flip_h = 1'b1;
        fs(10'd100, 10'd50);
        probe("flip", 10'd100, 10'd50, 1'b1, 12'd31, 4'h2, 1'b1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
